// File: rtl/snoop_arb_pkg.sv
// Shared definitions for the snoop arbiter: arbiter state encoding and a
// ceiling-log2 helper used to size the core-index registers.
package snoop_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Ceiling log2, never smaller than 1 so a 2-core build still gets an index bit.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/snoop_arb_rr_pick.sv
// Round-robin candidate picker: first set request at or above ptr, wrapping.
// Purely combinational.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         valid
);

  // Scan N positions starting at ptr and keep the first hit.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) begin
        j = j - N;
      end else begin
        j = j;
      end
      if (!valid && req[j]) begin
        valid = 1'b1;
        idx   = W'(j);
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/snoop_arb.sv
// Snoop arbiter: hands each packet from the snooper to one packet-filter core
// chosen round-robin, and gates the snooper write/done strobes to that core.
// Optional feature: define SNOOP_ARB_REG_OUT_EN to register the broadcast data
// and the per-core strobes (one cycle later); the handshake stays combinational.
module snoop_arb
  import snoop_arb_pkg::*;
#(
  parameter int N             = 4,
  parameter int SN_ADDR_WIDTH = 10,
  parameter int SN_DATA_WIDTH = 64,
  parameter int INC_WIDTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SN_ADDR_WIDTH-1:0] addr,
  input  logic [SN_DATA_WIDTH-1:0] wr_data,
  input  logic                     wr_en,
  input  logic [INC_WIDTH-1:0]     byte_inc,
  input  logic                     done,
  output logic                     rdy,
  input  logic                     ack,
  output logic [SN_ADDR_WIDTH-1:0] sn_addr,
  output logic [SN_DATA_WIDTH-1:0] sn_wr_data,
  output logic [INC_WIDTH-1:0]     sn_byte_inc,
  output logic [N-1:0]             sn_wr_en,
  output logic [N-1:0]             sn_done,
  input  logic [N-1:0]             rdy_for_sn,
  output logic [N-1:0]             rdy_for_sn_ack
);

  localparam int SEL_W = clog2(N);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0]  cand_idx_s;
  logic              cand_vld_s;
  logic [N-1:0]      wr_en_s;
  logic [N-1:0]      done_s;

  rr_pick #(
    .N (N),
    .W (SEL_W)
  ) u_rr_pick (
    .req   (rdy_for_sn),
    .ptr   (rr_ptr_q),
    .idx   (cand_idx_s),
    .valid (cand_vld_s)
  );

  // Offer a core while idle and grant it in the same cycle as the handshake.
  always_comb begin
    rdy            = 1'b0;
    rdy_for_sn_ack = '0;
    if (rst && (state_q == ST_IDLE)) begin
      rdy = cand_vld_s;
    end else begin
      rdy = 1'b0;
    end
    if (rdy && ack) begin
      rdy_for_sn_ack[cand_idx_s] = 1'b1;
    end else begin
      rdy_for_sn_ack = '0;
    end
  end

  // Next-state: take ownership on handshake, release and advance pointer on done.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (rdy && ack) begin
          state_d = ST_BUSY;
          sel_d   = cand_idx_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (done) begin
          state_d  = ST_IDLE;
          rr_ptr_d = (sel_q == SEL_W'(N - 1)) ? '0 : sel_q + SEL_W'(1);
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Arbiter state registers; reset abandons any packet in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Route write and done strobes only to the owning core; drop them when idle.
  always_comb begin
    wr_en_s = '0;
    done_s  = '0;
    if (state_q == ST_BUSY) begin
      wr_en_s[sel_q] = wr_en;
      done_s[sel_q]  = done;
    end else begin
      wr_en_s = '0;
      done_s  = '0;
    end
  end

`ifdef SNOOP_ARB_REG_OUT_EN
  logic [SN_ADDR_WIDTH-1:0] sn_addr_q;
  logic [SN_DATA_WIDTH-1:0] sn_wr_data_q;
  logic [INC_WIDTH-1:0]     sn_byte_inc_q;
  logic [N-1:0]             sn_wr_en_q;
  logic [N-1:0]             sn_done_q;

  // Output stage: cores see data and strobes one cycle after the snooper.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sn_addr_q     <= '0;
      sn_wr_data_q  <= '0;
      sn_byte_inc_q <= '0;
      sn_wr_en_q    <= '0;
      sn_done_q     <= '0;
    end else begin
      sn_addr_q     <= addr;
      sn_wr_data_q  <= wr_data;
      sn_byte_inc_q <= byte_inc;
      sn_wr_en_q    <= wr_en_s;
      sn_done_q     <= done_s;
    end
  end

  assign sn_addr     = sn_addr_q;
  assign sn_wr_data  = sn_wr_data_q;
  assign sn_byte_inc = sn_byte_inc_q;
  assign sn_wr_en    = sn_wr_en_q;
  assign sn_done     = sn_done_q;
`else
  assign sn_addr     = addr;
  assign sn_wr_data  = wr_data;
  assign sn_byte_inc = byte_inc;
  assign sn_wr_en    = wr_en_s;
  assign sn_done     = done_s;
`endif

endmodule

// File: doc/snoop_arb.md
SNOOP_ARB -- requirements
Module: snoop_arb

Interface
REQ-001 N, 4, number of packetfilter cores served; legal range 2..64.
REQ-002 SN_ADDR_WIDTH, 10, snooper write address width.
REQ-003 SN_DATA_WIDTH, 64, snooper write data width.
REQ-004 INC_WIDTH, 4, byte-increment field width.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-007 addr  input  SN_ADDR_WIDTH  snooper write address.
REQ-008 wr_data  input  SN_DATA_WIDTH  snooper write data.
REQ-009 wr_en  input  1  snooper write strobe.
REQ-010 byte_inc  input  INC_WIDTH  bytes added by this write.
REQ-011 done  input  1  single-cycle end-of-packet pulse from snooper.
REQ-012 rdy  output  1  some core can accept a packet.
REQ-013 ack  input  1  snooper accepts the offered core; handshake when rdy && ack.
REQ-014 sn_addr, sn_wr_data, sn_byte_inc  output  SN_ADDR_WIDTH / SN_DATA_WIDTH / INC_WIDTH  broadcast to all cores.
REQ-015 sn_wr_en  output  N  per-core gated write strobe.
REQ-016 sn_done  output  N  per-core gated done.
REQ-017 rdy_for_sn  input  N  core i has an empty packet buffer.
REQ-018 rdy_for_sn_ack  output  N  one-hot grant to core i on handshake.

Function
REQ-019 Two states: IDLE (no packet owned) and BUSY (one core owns the current packet).
REQ-020 IDLE: rdy = OR(rdy_for_sn), combinational; BUSY: rdy = 0.
REQ-021 Candidate = first i with rdy_for_sn[i]=1, searching from rr_ptr upward, wrapping N-1 -> 0.
REQ-022 On rdy && ack in IDLE: rdy_for_sn_ack[candidate]=1 same cycle (combinational, exactly one bit), sel <= candidate, state <= BUSY.
REQ-023 ack without rdy: ignored, no grant, no state change.
REQ-024 BUSY: sn_wr_en[sel] = wr_en, sn_done[sel] = done; all other bits 0.
REQ-025 IDLE: wr_en and done are dropped; sn_wr_en = 0, sn_done = 0.
REQ-026 BUSY and done=1: state <= IDLE, rr_ptr <= (sel+1) mod N next cycle.
REQ-027 wr_en and done in the same cycle: both forwarded to core sel in that cycle.
REQ-028 ack during the done cycle is ignored (rdy=0); earliest next grant is the cycle after done.
REQ-029 Changes of rdy_for_sn while BUSY do not affect sel or gating.
REQ-030 addr, wr_data, byte_inc pass through unregistered (zero latency) with macro off.

Reset
REQ-031 While rst=0: state=IDLE, sel=0, rr_ptr=0, and rdy, rdy_for_sn_ack, sn_wr_en, sn_done are all 0, independent of clk.
REQ-032 Reset mid-packet abandons the packet; no sn_done is issued to the owning core.

Configuration
REQ-033 Macro SNOOP_ARB_REG_OUT_EN defined: sn_addr, sn_wr_data, sn_byte_inc, sn_wr_en and sn_done are registered, so they reach the cores exactly 1 cycle later; the registered outputs reset to 0.
REQ-034 With the macro defined, the handshake path (rdy, rdy_for_sn_ack) stays combinational.
REQ-035 Macro undefined: all outputs are combinational as in REQ-024/REQ-030.

Structure
REQ-036 Shared package/header holds the IDLE/BUSY encodings and the CLOG2 helper; sel and rr_ptr width = CLOG2(N).
REQ-037 The round-robin search is a sub-module rr_pick (inputs: request vector, pointer; outputs: index, valid); it is purely combinational.

Verification
REQ-038 All benches run with N=4.
REQ-039 rdy_for_sn=4'b0000, ack=1 -> rdy=0, rdy_for_sn_ack=0, state stays IDLE.
REQ-040 rdy_for_sn=4'b0110, rr_ptr=0, ack=1 -> rdy_for_sn_ack=4'b0010; 3 writes with addr=0..2 -> sn_wr_en pulses only on bit 1; done -> sn_done=4'b0010; rr_ptr=2.
REQ-041 Grant on core 3, then done -> rr_ptr wraps to 0; next with rdy_for_sn=4'b1001 -> grant 4'b0001.
REQ-042 done and ack asserted in the same cycle while BUSY -> no grant that cycle; grant follows on the next cycle with ack held.
REQ-043 rst=0 mid-packet after 2 writes -> all outputs 0 immediately; after release, wr_en with no handshake -> sn_wr_en stays 0.
REQ-044 Macro defined: wr_en at cycle t -> sn_wr_en[sel] at t+1 with matching sn_wr_data; the grant remains same-cycle.
